// File: rtl/ps2_frame_receiver_pkg.sv
// Shared definitions for the PS/2 receive path: frame geometry, FSM state
// encoding, default timeout and the parity helper used at the stop bit.
package ps2_frame_receiver_pkg;

  // Start + 8 data + parity + stop.
  localparam int PS2_FRAME_BITS = 11;
  localparam int DATA_BITS      = PS2_FRAME_BITS - 3;

  // 2 ms at 50 MHz: a stalled frame is abandoned after this many idle cycles.
  localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data,
                                         input logic                 parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_frame_receiver_clk_filter.sv
// Input conditioning for the PS/2 pins: both pins are synchronised, the clock
// is additionally de-glitched, and a one-cycle strobe marks each filtered
// clock falling edge. The data pin is only synchronised so that it lines up
// with the clock path's synchroniser depth. SYNC_STAGES must be at least 2.
module ps2_frame_receiver_clk_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clk_raw,
  input  logic dat_raw,
  output logic dat_sync,
  output logic sample
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] clk_sync_p0;
  logic [SYNC_STAGES-1:0] dat_sync_p0;
  logic                   clk_synced;
  logic                   clk_filt;
  logic                   clk_filt_q;
  logic [CNT_W-1:0]       stable_cnt;

  // Synchroniser chains; idle-high pins so reset loads ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_p0 <= '1;
      dat_sync_p0 <= '1;
    end else begin
      clk_sync_p0 <= {clk_sync_p0[SYNC_STAGES-2:0], clk_raw};
      dat_sync_p0 <= {dat_sync_p0[SYNC_STAGES-2:0], dat_raw};
    end
  end

  assign clk_synced = clk_sync_p0[SYNC_STAGES-1];
  assign dat_sync   = dat_sync_p0[SYNC_STAGES-1];

  // Glitch filter: the filtered clock follows the synced clock only after
  // FILTER_LEN consecutive cycles of disagreement; any agreement restarts it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_filt   <= 1'b1;
      clk_filt_q <= 1'b1;
      stable_cnt <= '0;
    end else begin
      clk_filt_q <= clk_filt;
      if (clk_synced != clk_filt) begin
        if (stable_cnt == CNT_LAST) begin
          clk_filt   <= clk_synced;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + CNT_W'(1);
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

  // High for exactly the one cycle after the filtered clock drops.
  assign sample = clk_filt_q & ~clk_filt;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver. Turns the raw PS2_CLK/PS2_DAT pins into
// validated scan-code bytes with a one-cycle rx_valid strobe, and flags
// discarded frames (bad parity, bad stop bit, stalled frame) with rx_error.
// The pins are only ever read; there is no host-to-device path.
module ps2_frame_receiver
  import ps2_frame_receiver_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 PS2_CLK,
  input  logic                 PS2_DAT,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_error,
  output logic                 busy
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

  ps2_state_t           state;
  logic [2:0]           bit_cnt;
  logic [TO_W-1:0]      to_cnt;
  logic [DATA_BITS-1:0] shift_p1;
  logic                 parity_p1;
  logic                 dat;
  logic                 sample;

  ps2_frame_receiver_clk_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_clk_filter (
    .clock    (clock),
    .reset    (reset),
    .clk_raw  (PS2_CLK),
    .dat_raw  (PS2_DAT),
    .dat_sync (dat),
    .sample   (sample)
  );

  // Payload capture: data bits shift in LSB-first, parity latched separately.
  // Only meaningful once the FSM reaches STOP, so it needs no reset.
  always_ff @(posedge clock) begin
    if (sample && state == ST_DATA) begin
      shift_p1 <= {dat, shift_p1[DATA_BITS-1:1]};
    end
    if (sample && state == ST_PARITY) begin
      parity_p1 <= dat;
    end
  end

  // Frame FSM with timeout; a sample event takes priority over timeout expiry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      to_cnt   <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      if (sample) begin
        to_cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (!dat) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            if (bit_cnt == LAST_BIT) begin
              state <= ST_PARITY;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          ST_PARITY: begin
            state <= ST_STOP;
          end
          ST_STOP: begin
            if (dat && odd_parity_ok(shift_p1, parity_p1)) begin
              rx_data  <= shift_p1;
              rx_valid <= 1'b1;
            end else begin
              rx_error <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end else if (state != ST_IDLE) begin
        if (to_cnt == TO_LAST) begin
          rx_error <= 1'b1;
          state    <= ST_IDLE;
          to_cnt   <= '0;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed + randomized bench for ps2_frame_receiver. Frames are generated at
// the pin level; expected outcomes come from the PS/2 framing rules applied to
// the transmitted bits. PS/2 clock period is scaled down to keep runs short.
module tb_ps2_frame_receiver;

  localparam int SYNC = 2;
  localparam int FILT = 8;
  localparam int TOUT = 400;
  localparam int HALF = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic       busy;

  ps2_frame_receiver #(
    .SYNC_STAGES    (SYNC),
    .FILTER_LEN     (FILT),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .PS2_CLK  (PS2_CLK),
    .PS2_DAT  (PS2_DAT),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_error (rx_error),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Observed output pulses, in order of appearance.
  logic        ev_kind_q[$];   // 1 = rx_valid, 0 = rx_error
  logic [7:0]  ev_data_q[$];
  int unsigned ev_cyc_q[$];
  int          busy_cnt = 0;
  int          both_cnt = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (rx_valid) begin
        ev_kind_q.push_back(1'b1);
        ev_data_q.push_back(rx_data);
        ev_cyc_q.push_back(cyc);
      end
      if (rx_error) begin
        ev_kind_q.push_back(1'b0);
        ev_data_q.push_back(8'h00);
        ev_cyc_q.push_back(cyc);
      end
      if (rx_valid && rx_error) both_cnt++;
      if (busy) busy_cnt++;
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Parity bit a well-behaved keyboard sends: total ones (data+parity) odd.
  function automatic logic good_parity(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return (ones % 2 == 0);
  endfunction

  // Reference verdict for a frame, straight from the framing rules.
  function automatic logic frame_ok(input logic [7:0] d, input logic p, input logic s);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    if (p) ones++;
    return s && (ones % 2 == 1);
  endfunction

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction

  int unsigned last_fall_cyc = 0;

  // Bits lo..hi of a frame: data changes mid-high, then a full low half-period.
  task automatic send_range(input logic [10:0] bits, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      repeat (HALF/2) @(negedge clock);
      PS2_DAT = bits[i];
      repeat (HALF/2) @(negedge clock);
      PS2_CLK = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clock);
      PS2_CLK = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_one(input string tag, input int base, input logic kind,
                            input logic [7:0] data);
    chk({tag, "_count"}, ev_kind_q.size(), base + 1);
    if (ev_kind_q.size() > base) begin
      chk({tag, "_kind"}, 32'(ev_kind_q[base]), 32'(kind));
      if (kind) chk({tag, "_data"}, 32'(ev_data_q[base]), 32'(data));
    end
  endtask

  int          base;
  int          calib;
  int unsigned fall_ref;
  int          bsave;
  logic [10:0] fr;
  logic [7:0]  d;
  logic        p, s, ok;
  logic [7:0]  model_last;

  initial begin
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    reset   = 1'b1;
    calib   = SYNC + FILT + 1;
    idle(3);
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_rx_valid", 32'(rx_valid), 32'h0);
    chk("reset_rx_error", 32'(rx_error), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    idle(20);

    // Single good frame 0x29; also calibrate pin-edge to pulse latency.
    base = ev_kind_q.size();
    fr = mk_frame(8'h29, good_parity(8'h29), 1'b1);
    send_range(fr, 0, 1);
    chk("t1_busy_mid", 32'(busy), 32'h1);
    send_range(fr, 2, 10);
    idle(20);
    expect_one("t1", base, 1'b1, 8'h29);
    if (ev_cyc_q.size() > base) calib = int'(ev_cyc_q[base] - last_fall_cyc);
    chk("t1_rx_data", 32'(rx_data), 32'h29);
    chk("t1_busy_end", 32'(busy), 32'h0);

    // Back-to-back 0xF0, 0x29.
    base = ev_kind_q.size();
    send_range(mk_frame(8'hF0, good_parity(8'hF0), 1'b1), 0, 10);
    send_range(mk_frame(8'h29, good_parity(8'h29), 1'b1), 0, 10);
    idle(20);
    chk("t2_count", ev_kind_q.size(), base + 2);
    if (ev_kind_q.size() >= base + 2) begin
      chk("t2_first", {23'd0, ev_kind_q[base], ev_data_q[base]}, {23'd0, 1'b1, 8'hF0});
      chk("t2_second", {23'd0, ev_kind_q[base+1], ev_data_q[base+1]}, {23'd0, 1'b1, 8'h29});
    end

    // Wrong parity on 0x1C: error, previous byte held.
    base = ev_kind_q.size();
    send_range(mk_frame(8'h1C, ~good_parity(8'h1C), 1'b1), 0, 10);
    idle(20);
    expect_one("t3", base, 1'b0, 8'h00);
    chk("t3_rx_data_held", 32'(rx_data), 32'h29);

    // Bad stop bit on 0x5A, then a clean 0x5A.
    base = ev_kind_q.size();
    send_range(mk_frame(8'h5A, good_parity(8'h5A), 1'b0), 0, 10);
    idle(20);
    expect_one("t4_bad", base, 1'b0, 8'h00);
    chk("t4_busy", 32'(busy), 32'h0);
    base = ev_kind_q.size();
    send_range(mk_frame(8'h5A, good_parity(8'h5A), 1'b1), 0, 10);
    idle(20);
    expect_one("t4_good", base, 1'b1, 8'h5A);

    // Stall after start + 4 data bits: timeout error, then recovery with 0x75.
    base = ev_kind_q.size();
    send_range(mk_frame(8'h75, good_parity(8'h75), 1'b1), 0, 4);
    fall_ref = last_fall_cyc;
    chk("t5_busy_stalled", 32'(busy), 32'h1);
    idle(TOUT + 40);
    expect_one("t5_timeout", base, 1'b0, 8'h00);
    if (ev_cyc_q.size() > base)
      chk("t5_timeout_cycle", ev_cyc_q[base] - fall_ref, 32'(calib + TOUT));
    chk("t5_busy_after", 32'(busy), 32'h0);
    base = ev_kind_q.size();
    send_range(mk_frame(8'h75, good_parity(8'h75), 1'b1), 0, 10);
    idle(20);
    expect_one("t5_recover", base, 1'b1, 8'h75);

    // Randomized frames with occasional parity/stop corruption.
    model_last = 8'h75;
    for (int k = 0; k < 24; k++) begin
      d  = 8'($urandom_range(0, 255));
      p  = good_parity(d) ^ ($urandom_range(0, 3) == 0);
      s  = ($urandom_range(0, 7) != 0);
      ok = frame_ok(d, p, s);
      if (ok) model_last = d;
      base = ev_kind_q.size();
      send_range(mk_frame(d, p, s), 0, 10);
      idle(10);
      expect_one($sformatf("rnd%0d", k), base, ok, d);
      chk($sformatf("rnd%0d_rx_data", k), 32'(rx_data), 32'(model_last));
    end

    // Short low glitch while idle must be invisible.
    idle(20);
    base  = ev_kind_q.size();
    bsave = busy_cnt;
    PS2_CLK = 1'b0;
    idle(3);
    PS2_CLK = 1'b1;
    idle(40);
    chk("t6_glitch_events", ev_kind_q.size(), base);
    chk("t6_glitch_busy", busy_cnt, bsave);

    // Reset in the middle of a frame: asynchronous clear, no pulses.
    send_range(mk_frame(8'h33, good_parity(8'h33), 1'b1), 0, 5);
    chk("t6_busy_before_reset", 32'(busy), 32'h1);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_rx_data", 32'(rx_data), 32'h00);
    chk("t6_async_rx_valid", 32'(rx_valid), 32'h0);
    chk("t6_async_rx_error", 32'(rx_error), 32'h0);
    chk("t6_async_busy", 32'(busy), 32'h0);
    idle(4);
    reset = 1'b0;
    base = ev_kind_q.size();
    idle(200);
    chk("t6_no_pulses", ev_kind_q.size(), base);
    chk("t6_busy_idle", 32'(busy), 32'h0);
    send_range(mk_frame(8'h33, good_parity(8'h33), 1'b1), 0, 10);
    idle(20);
    expect_one("t6_recover", base, 1'b1, 8'h33);

    chk("never_both_pulses", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
